// File: rtl/idct_row_stream_pkg.sv
// Shared constants, HEVC transform tables and enums for the streaming row IDCT.
// Table entries encode {negate, coefficient index} into COEF_TAB.
package idct_pkg;

    typedef enum logic {SZ4 = 1'b0, SZ8 = 1'b1} size_e;
    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_e;

    localparam logic [7:0] C64 = 8'd64;
    localparam logic [7:0] C89 = 8'd89;
    localparam logic [7:0] C83 = 8'd83;
    localparam logic [7:0] C75 = 8'd75;
    localparam logic [7:0] C50 = 8'd50;
    localparam logic [7:0] C36 = 8'd36;
    localparam logic [7:0] C18 = 8'd18;

    localparam int NUM_COEF = 7;
    localparam logic [7:0] COEF_TAB [NUM_COEF] = '{C64, C89, C83, C75, C50, C36, C18};

    // T8[k][n]: bit 3 = negative, bits 2:0 = index into COEF_TAB
    localparam logic [3:0] T8 [8][8] = '{
        '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0},
        '{4'h1, 4'h3, 4'h4, 4'h6, 4'hE, 4'hC, 4'hB, 4'h9},
        '{4'h2, 4'h5, 4'hD, 4'hA, 4'hA, 4'hD, 4'h5, 4'h2},
        '{4'h3, 4'hE, 4'h9, 4'hC, 4'h4, 4'h1, 4'h6, 4'hB},
        '{4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0},
        '{4'h4, 4'h9, 4'h6, 4'h3, 4'hB, 4'hE, 4'h1, 4'hC},
        '{4'h5, 4'hA, 4'h2, 4'hD, 4'hD, 4'h2, 4'hA, 4'h5},
        '{4'h6, 4'hC, 4'h3, 4'h9, 4'h1, 4'hB, 4'h4, 4'hE}
    };

    localparam logic [3:0] T4 [4][4] = '{
        '{4'h0, 4'h0, 4'h0, 4'h0},
        '{4'h2, 4'h5, 4'hD, 4'hA},
        '{4'h0, 4'h8, 4'h8, 4'h0},
        '{4'h5, 4'hA, 4'h2, 4'hD}
    };

    function automatic logic [2:0] last_idx(size_e sz);
        return (sz == SZ8) ? 3'd7 : 3'd3;
    endfunction

endpackage

// File: rtl/idct_row_stream_if.sv
// Input coefficient stream and output sample stream of the row IDCT.
interface idct_row_stream_if #(
    parameter int WIDTH_X = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH_X-1:0] in_data;
    logic                      in_size;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [WIDTH_X-1:0] out_data;
    logic                      out_last;

    modport master (
        output in_valid, in_data, in_size, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_size, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/idct_row_stream_cmul.sv
// Constant multiplier: x * COEF built from shifted copies of x, one per set bit.
module idct_cmul #(
    parameter int         WIDTH_X   = 16,
    parameter int         WIDTH_ACC = 26,
    parameter logic [7:0] COEF      = 8'd64
) (
    input  logic signed [WIDTH_X-1:0]   x,
    output logic signed [WIDTH_ACC-1:0] prod
);
    logic signed [WIDTH_ACC-1:0] x_ext;

    assign x_ext = {{(WIDTH_ACC-WIDTH_X){x[WIDTH_X-1]}}, x};

    always_comb begin
        prod = '0;
        for (int b = 0; b < 8; b++) begin
            if (COEF[b]) begin
                prod = prod + (x_ext <<< b);
            end
        end
    end
endmodule

// File: rtl/idct_row_stream.sv
// Streaming 4/8-point HEVC row IDCT with valid/ready on both sides and a drain buffer.
// Define IDCT_ROW_SAT_EN to clamp results to WIDTH_X instead of wrapping.
//
// state | meaning
// ACC   | accepting coefficients; completed rows go straight to the output buffer
// HOLD  | completed row parked in the hold register until the output buffer drains
module idct_row_stream
    import idct_pkg::*;
#(
    parameter int WIDTH_X   = 16,
    parameter int WIDTH_ACC = 26,
    parameter int SHIFT     = 7,
    parameter int ADD       = 1 << (SHIFT - 1)
) (
    input logic clk,
    input logic rst,
    idct_row_stream_if.slave io
);
    localparam logic signed [WIDTH_ACC-1:0] ADD_ACC = WIDTH_ACC'(ADD);
`ifdef IDCT_ROW_SAT_EN
    localparam logic signed [WIDTH_ACC-1:0] SAT_MAX = WIDTH_ACC'((1 << (WIDTH_X - 1)) - 1);
    localparam logic signed [WIDTH_ACC-1:0] SAT_MIN = ~SAT_MAX;
`endif

    state_e state_q, state_d;

    logic [2:0] k_q;
    logic [2:0] k_last;
    size_e      size_q;
    size_e      row_sz;
    logic       pend_q;
    logic [3:0] code;

    logic signed [WIDTH_ACC-1:0] prod  [NUM_COEF];
    logic signed [WIDTH_ACC-1:0] term  [8];
    logic signed [WIDTH_ACC-1:0] acc_q [8];
    logic signed [WIDTH_X-1:0]   res    [8];
    logic signed [WIDTH_X-1:0]   buf_q  [8];
    logic signed [WIDTH_X-1:0]   hold_q [8];

    size_e      buf_sz_q, hold_sz_q;
    logic [2:0] rd_q;
    logic       out_valid_q, out_last_c;
    logic       in_ready_c, in_fire, out_fire, last_fire, buf_free;
    logic       load_res, load_hold, load_from_hold;

    function automatic logic signed [WIDTH_X-1:0] to_out(logic signed [WIDTH_ACC-1:0] a);
`ifdef IDCT_ROW_SAT_EN
        logic signed [WIDTH_ACC-1:0] sh;
        sh = a >>> SHIFT;
        if (sh > SAT_MAX) return SAT_MAX[WIDTH_X-1:0];
        if (sh < SAT_MIN) return SAT_MIN[WIDTH_X-1:0];
        return sh[WIDTH_X-1:0];
`else
        return WIDTH_X'(a >>> SHIFT);
`endif
    endfunction

    for (genvar c = 0; c < NUM_COEF; c++) begin : g_cmul
        idct_cmul #(
            .WIDTH_X  (WIDTH_X),
            .WIDTH_ACC(WIDTH_ACC),
            .COEF     (COEF_TAB[c])
        ) u_cmul (
            .x   (io.in_data),
            .prod(prod[c])
        );
    end

    // The row size comes from in_size only on k=0; later coefficients use the latched size.
    always_comb begin
        row_sz = (k_q == 3'd0) ? size_e'(io.in_size) : size_q;
        k_last = last_idx(row_sz);
        code   = '0;
        for (int n = 0; n < 8; n++) begin
            term[n] = '0;
            if (row_sz == SZ8) begin
                code    = T8[k_q][3'(n)];
                term[n] = code[3] ? -prod[code[2:0]] : prod[code[2:0]];
            end else if (n < 4) begin
                code    = T4[k_q[1:0]][2'(n)];
                term[n] = code[3] ? -prod[code[2:0]] : prod[code[2:0]];
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 8; n++) begin
            res[n] = to_out(acc_q[n]);
        end
    end

    assign in_fire    = io.in_valid && in_ready_c;
    assign out_last_c = out_valid_q && (rd_q == last_idx(buf_sz_q));
    assign out_fire   = out_valid_q && io.out_ready;
    assign last_fire  = out_fire && out_last_c;
    assign buf_free   = !out_valid_q || last_fire;

    assign io.in_ready  = in_ready_c;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_valid_q ? buf_q[rd_q] : '0;
    assign io.out_last  = out_last_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // in_ready depends only on registered state, never on out_ready.
    always_comb begin
        state_d        = state_q;
        in_ready_c     = 1'b0;
        load_res       = 1'b0;
        load_hold      = 1'b0;
        load_from_hold = 1'b0;
        case (state_q)
            ACC: begin
                in_ready_c = 1'b1;
                if (pend_q) begin
                    if (buf_free) begin
                        load_res = 1'b1;
                    end else begin
                        load_hold = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (last_fire) begin
                    load_from_hold = 1'b1;
                    state_d        = ACC;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q    <= '0;
            size_q <= SZ4;
            pend_q <= 1'b0;
            for (int n = 0; n < 8; n++) acc_q[n] <= '0;
        end else begin
            pend_q <= in_fire && (k_q == k_last);
            if (in_fire) begin
                for (int n = 0; n < 8; n++) begin
                    acc_q[n] <= (k_q == 3'd0) ? ADD_ACC + term[n] : acc_q[n] + term[n];
                end
                if (k_q == 3'd0) size_q <= row_sz;
                k_q <= (k_q == k_last) ? 3'd0 : k_q + 3'd1;
            end
        end
    end

    // Results are captured at the pending edge, so the next row may overwrite acc_q meanwhile.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            buf_sz_q    <= SZ4;
            hold_sz_q   <= SZ4;
            for (int n = 0; n < 8; n++) begin
                buf_q[n]  <= '0;
                hold_q[n] <= '0;
            end
        end else begin
            if (load_hold) begin
                hold_sz_q <= size_q;
                for (int n = 0; n < 8; n++) hold_q[n] <= res[n];
            end
            if (load_res) begin
                buf_sz_q    <= size_q;
                rd_q        <= '0;
                out_valid_q <= 1'b1;
                for (int n = 0; n < 8; n++) buf_q[n] <= res[n];
            end else if (load_from_hold) begin
                buf_sz_q    <= hold_sz_q;
                rd_q        <= '0;
                out_valid_q <= 1'b1;
                for (int n = 0; n < 8; n++) buf_q[n] <= hold_q[n];
            end else if (last_fire) begin
                out_valid_q <= 1'b0;
                rd_q        <= '0;
            end else if (out_fire) begin
                rd_q <= rd_q + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_idct_row_stream.sv
// Scoreboard bench for idct_row_stream: expected samples queued per row, popped on output transfers.
module tb_idct_row_stream;
    localparam int WX = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    idct_row_stream_if #(.WIDTH_X(WX)) io ();

    idct_row_stream #(
        .WIDTH_X  (WX),
        .WIDTH_ACC(26),
        .SHIFT    (7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    typedef struct {
        logic signed [15:0] data;
        logic               last;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   last_pos [$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   stall_cnt = 0;
    int   out_cnt   = 0;
    int   rdy_mode  = 1;
    logic out_rdy   = 1'b1;
    int   cur_x [8];

    int M8 [8][8] = '{
        '{64,  64,  64,  64,  64,  64,  64,  64},
        '{89,  75,  50,  18, -18, -50, -75, -89},
        '{83,  36, -36, -83, -83, -36,  36,  83},
        '{75, -18, -89, -50,  50,  89,  18, -75},
        '{64, -64, -64,  64,  64, -64, -64,  64},
        '{50, -89,  18,  75, -75, -18,  89, -50},
        '{36, -83,  83, -36, -36,  83, -83,  36},
        '{18, -50,  75, -89,  89, -75,  50, -18}
    };

    assign io.out_ready = out_rdy;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic signed [15:0] model_y(input int n, input int n_pts);
        longint acc = 64;
        for (int k = 0; k < n_pts; k++) begin
            acc += longint'((n_pts == 8) ? M8[k][n] : M8[2*k][n]) * longint'(cur_x[k]);
        end
        acc = acc >>> 7;
`ifdef IDCT_ROW_SAT_EN
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
`endif
        return 16'(acc);
    endfunction

    function automatic int rand_x();
        logic signed [15:0] r;
        r = 16'($urandom);
        return int'(r);
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_rdy = 1'b0;
            1:       out_rdy = 1'b1;
            default: out_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (!rst && io.out_valid && io.out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", io.out_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", io.out_data, mon_e.data);
                check("out_last", io.out_last, mon_e.last);
            end
            if (io.out_last) last_pos.push_back(out_cnt);
        end
        if (!rst && io.in_valid && !io.in_ready) stall_cnt++;
    end

    task automatic send_coef(input logic signed [15:0] x, input logic sz);
        int   waited = 0;
        logic ok     = 1'b0;
        io.in_valid = 1'b1;
        io.in_data  = x;
        io.in_size  = sz;
        while (!ok && waited < 200) begin
            @(negedge clk);
            ok = io.in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!ok) check("in_accept_timeout", io.in_ready, 1'b1);
    endtask

    // k>0 carries a random in_size, which the DUT must ignore.
    task automatic send_row(input int n_pts, input bit keep_valid);
        for (int k = 0; k < n_pts; k++) begin
            send_coef(16'(cur_x[k]), (k == 0) ? (n_pts == 8) : 1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < n_pts; n++) begin
            exp_q.push_back('{data: model_y(n, n_pts), last: (n == n_pts - 1)});
        end
        if (!keep_valid) io.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int c = 0;
        while (exp_q.size() != 0 && c < max_cyc) begin
            @(posedge clk);
            c++;
        end
        check("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int x0, input int x1, input bit rnd);
        for (int k = 0; k < 8; k++) cur_x[k] = rnd ? rand_x() : 0;
        if (!rnd) begin
            cur_x[0] = x0;
            cur_x[1] = x1;
        end
    endtask

    initial begin
        int ob, lb, sb;
        io.in_valid = 1'b0;
        io.in_data  = '0;
        io.in_size  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", io.in_ready, 1'b1);
        check("rst_out_valid", io.out_valid, 1'b0);
        check("rst_out_data", io.out_data, 0);
        check("rst_out_last", io.out_last, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // DC 8-point with latency
        set_row(64, 0, 1'b0);
        send_row(8, 1'b0);
        @(negedge clk);
        check("lat_cycle1_valid", io.out_valid, 1'b0);
        @(negedge clk);
        check("lat_cycle2_valid", io.out_valid, 1'b1);
        check("dc_first_sample", io.out_data, 32);
        wait_drain(100);

        // AC 4-point
        set_row(0, 100, 1'b0);
        send_row(4, 1'b0);
        wait_drain(100);

        // back-to-back 4, 8, 4
        ob = out_cnt;
        lb = last_pos.size();
        sb = stall_cnt;
        set_row(0, 0, 1'b1);
        send_row(4, 1'b1);
        set_row(0, 0, 1'b1);
        send_row(8, 1'b1);
        set_row(0, 0, 1'b1);
        send_row(4, 1'b0);
        check("b2b_stalls", stall_cnt - sb, 0);
        wait_drain(200);
        check("b2b_last_count", last_pos.size() - lb, 3);
        if (last_pos.size() - lb == 3) begin
            check("b2b_last_pos0", last_pos[lb] - ob, 4);
            check("b2b_last_pos1", last_pos[lb+1] - ob, 12);
            check("b2b_last_pos2", last_pos[lb+2] - ob, 16);
        end

        // backpressure across two 8-point rows
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        set_row(0, 0, 1'b1);
        send_row(8, 1'b1);
        set_row(0, 0, 1'b1);
        send_row(8, 1'b0);
        repeat (4) @(negedge clk);
        check("bp_in_ready", io.in_ready, 1'b0);
        check("bp_out_valid", io.out_valid, 1'b1);
        check("bp_pending", exp_q.size(), 16);
        check("bp_held_data", io.out_data, exp_q[0].data);
        rdy_mode = 1;
        wait_drain(200);
        @(negedge clk);
        check("bp_in_ready_back", io.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // all-max 8-point (saturate or wrap)
        for (int k = 0; k < 8; k++) cur_x[k] = 32767;
        send_row(8, 1'b0);
        wait_drain(100);

        // reset after 3 of 8 coefficients
        set_row(0, 0, 1'b1);
        send_coef(16'(cur_x[0]), 1'b1);
        send_coef(16'(cur_x[1]), 1'b0);
        send_coef(16'(cur_x[2]), 1'b1);
        io.in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", io.out_valid, 1'b0);
        check("midrst_in_ready", io.in_ready, 1'b1);
        check("midrst_out_last", io.out_last, 1'b0);
        repeat (12) @(negedge clk);
        check("midrst_idle_valid", io.out_valid, 1'b0);
        @(posedge clk);
        #1;
        set_row(128, 0, 1'b0);
        send_row(8, 1'b0);
        wait_drain(100);

        // random sizes and data with random out_ready
        rdy_mode = 2;
        for (int r = 0; r < 8; r++) begin
            set_row(0, 0, 1'b1);
            send_row(($urandom_range(0, 1) != 0) ? 8 : 4, (r != 7));
        end
        wait_drain(1000);
        rdy_mode = 1;
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end
endmodule
